// File: rtl/barrett_ctrl_pkg.sv
// Shared types and constants for the Barrett reducer share controller.
package barrett_ctrl_pkg;

  localparam int BARRETT_LAT = 6;
  localparam int TAG_ID_W    = 4;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } bctl_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/barrett_reducer.sv
// Shared 6-stage Barrett reducer: o_r = i_x mod i_n, with i_mu = floor(2^(2K)/i_n).
// No reset on the datapath; n and mu must stay stable while operations are in flight.
module barrett_reducer #(
  parameter int K = 12
) (
  input  logic           clk,
  input  logic [2*K-1:0] i_x,
  input  logic [K-1:0]   i_n,
  input  logic [2*K:0]   i_mu,
  output logic [K-1:0]   o_r
);

  localparam int PW = 4 * K + 1;
  localparam int RW = K + 1;

  logic [RW-1:0] r_x1, r_q1, r_x2, r_qn2, r_d3, r_d4, r_d5;
  logic [K-1:0]  r_r6;

  // q underestimates x/n by at most one, so x - q*n lies in [0, 2n) and
  // only the low K+1 bits of every term are needed.
  always_ff @(posedge clk) begin
    r_x1  <= i_x[RW-1:0];
    r_q1  <= RW'((PW'(i_x) * PW'(i_mu)) >> (2 * K));
    r_x2  <= r_x1;
    r_qn2 <= r_q1 * RW'(i_n);
    r_d3  <= r_x2 - r_qn2;
    r_d4  <= r_d3;
    r_d5  <= r_d4;
    r_r6  <= (r_d5 >= RW'(i_n)) ? K'(r_d5 - RW'(i_n)) : r_d5[K-1:0];
  end

  assign o_r = r_r6;

endmodule

// File: rtl/rr_picker.sv
// Round-robin priority picker: grants the lowest requester at or after i_ptr,
// wrapping modulo N. Output is one-hot or zero.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic w_blocked;

  function automatic int rank_of(input int idx, input int ptr);
    return (idx + N - ptr) % N;
  endfunction

  // A requester wins when no requester of better rank is asking.
  always_comb begin
    o_grant   = '0;
    w_blocked = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_blocked = 1'b0;
      for (int j = 0; j < N; j++) begin
        w_blocked = w_blocked |
                    (i_req[j] & (rank_of(j, int'(i_ptr)) < rank_of(i, int'(i_ptr))));
      end
      o_grant[i] = i_req[i] & ~w_blocked;
    end
  end

endmodule

// File: rtl/barrett_share_ctrl.sv
// Time-shares one Barrett reducer among NREQ requesters with round-robin issue,
// tag-tracked result routing and drain-before-load modulus configuration.
module barrett_share_ctrl
  import barrett_ctrl_pkg::*;
#(
  parameter int K    = 12,
  parameter int NREQ = 2,
  parameter int LAT  = BARRETT_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][2*K-1:0]  req_x,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      cfg_valid,
  input  logic [K-1:0]              cfg_n,
  input  logic [2*K:0]              cfg_mu,
  output logic                      cfg_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [K-1:0]              rsp_r,
  output logic                      configured,
  output logic                      busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  bctl_state_t         r_state, w_state_nxt;
  logic [IDW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [NREQ-1:0]     w_grant, w_req_ready;
  logic                w_hs;
  logic [TAG_ID_W-1:0] w_id;
  logic [2*K-1:0]      w_x_sel, r_x_issue;
  tag_t [LAT:0]        r_tag;
  logic [K-1:0]        r_n;
  logic [2*K:0]        r_mu;
  logic                r_configured;
  logic                w_busy;

  rr_picker #(
    .N  (NREQ),
    .PW (IDW)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  barrett_reducer #(
    .K (K)
  ) u_reducer (
    .clk  (clk),
    .i_x  (r_x_issue),
    .i_n  (r_n),
    .i_mu (r_mu),
    .o_r  (rsp_r)
  );

  // Next-state and grant gating; a pending cfg always wins over new requests.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      UNCFG: begin
        if (cfg_valid) w_state_nxt = LOAD;
        else           w_state_nxt = UNCFG;
      end
      RUN: begin
        if (cfg_valid) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
          w_req_ready = w_grant;
        end
      end
      DRAIN: begin
        if (w_busy) w_state_nxt = DRAIN;
        else        w_state_nxt = LOAD;
      end
      LOAD:    w_state_nxt = RUN;
      default: w_state_nxt = UNCFG;
    endcase
  end

  // Encode the granted requester and select its operand.
  always_comb begin
    w_id    = '0;
    w_x_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_id    = w_id | (w_req_ready[i] ? TAG_ID_W'(i) : '0);
      w_x_sel = w_x_sel | ({(2*K){w_req_ready[i]}} & req_x[i]);
    end
  end

  assign w_hs = |w_req_ready;

  // Pointer moves past the winner only when something was actually issued.
  always_comb begin
    if (w_hs) begin
      w_rr_ptr_nxt = (w_id == TAG_ID_W'(NREQ - 1)) ? '0 : IDW'(w_id + TAG_ID_W'(1));
    end else begin
      w_rr_ptr_nxt = r_rr_ptr;
    end
  end

  // Tag-valid OR and result routing from the last tag stage.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      w_busy = w_busy | r_tag[k].valid;
    end
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = r_tag[LAT].valid & (r_tag[LAT].id == TAG_ID_W'(i));
    end
  end

  // Control state, pointer and tag shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= UNCFG;
      r_rr_ptr <= '0;
      r_tag    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_tag[0] <= '{valid: w_hs, id: w_id};
      for (int k = 1; k <= LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Modulus configuration, written only once the pipeline is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n          <= '0;
      r_mu         <= '0;
      r_configured <= 1'b0;
    end else if (r_state == LOAD) begin
      r_n          <= cfg_n;
      r_mu         <= cfg_mu;
      r_configured <= 1'b1;
    end else begin
      r_n          <= r_n;
      r_mu         <= r_mu;
      r_configured <= r_configured;
    end
  end

  // Issue register; tag validity qualifies it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_hs) r_x_issue <= w_x_sel;
    else      r_x_issue <= r_x_issue;
  end

  assign req_ready  = w_req_ready;
  assign cfg_ready  = (r_state == LOAD);
  assign configured = r_configured;
  assign busy       = w_busy;

endmodule

// File: tb/tb_barrett_share_ctrl.sv
// Directed bench for barrett_share_ctrl: table of single operations plus
// sequences for fairness, mid-stream config, reset with ops in flight and
// a lone requester. K = 13 so that both 3329 and 7681 fit in cfg_n.
module tb_barrett_share_ctrl;

  localparam int K    = 13;
  localparam int NREQ = 2;
  localparam int LAT  = 6;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0][2*K-1:0] req_x;
  logic [NREQ-1:0]          req_ready;
  logic                     cfg_valid;
  logic [K-1:0]             cfg_n;
  logic [2*K:0]             cfg_mu;
  logic                     cfg_ready;
  logic [NREQ-1:0]          rsp_valid;
  logic [K-1:0]             rsp_r;
  logic                     configured;
  logic                     busy;

  barrett_share_ctrl #(.K(K), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .cfg_valid(cfg_valid), .cfg_n(cfg_n), .cfg_mu(cfg_mu), .cfg_ready(cfg_ready),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .configured(configured), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           cyc;
    logic [1:0]   oh;
    logic [K-1:0] r;
  } exp_t;

  typedef struct {
    int             id;
    logic [2*K-1:0] x;
    logic [K-1:0]   r;
  } vec_t;

  exp_t         exp_q[$];
  logic [K-1:0] cur_n;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [2*K:0] mu_of(input int n);
    logic [63:0] t;
    t = (64'd1 << (2 * K)) / 64'(n);
    return t[2*K:0];
  endfunction

  function automatic logic [K-1:0] mod_of(input logic [2*K-1:0] x);
    logic [63:0] t;
    t = 64'(x) % 64'(cur_n);
    return t[K-1:0];
  endfunction

  // Expected response for a handshake in the current cycle.
  task automatic push_exp(input int id, input logic [K-1:0] r);
    exp_t e;
    e.cyc = cyc + 7;
    e.oh  = (id == 0) ? 2'b01 : 2'b10;
    e.r   = r;
    exp_q.push_back(e);
  endtask

  task automatic check_rsp();
    exp_t e;
    if (rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_spurious: got rsp_valid=%b r=%0d want none (cyc %0d)", rsp_valid, rsp_r, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_id", 64'(rsp_valid), 64'(e.oh));
        chk("rsp_r", 64'(rsp_r), 64'(e.r));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL rsp_missing: got none want rsp_valid=%b r=%0d at cyc %0d", e.oh, e.r, e.cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_rsp();
  endtask

  task automatic do_cfg(input int n, output int ncyc);
    bit got;
    got       = 1'b0;
    ncyc      = 0;
    cfg_n     = K'(n);
    cfg_mu    = mu_of(n);
    cfg_valid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      ncyc++;
      if (cfg_ready) got = 1'b1;
    end
    chk("cfg_ready_seen", 64'(got), 64'd1);
    tick();
    cfg_valid = 1'b0;
    cur_n     = K'(n);
    chk("configured", 64'(configured), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_configured"}, 64'(configured), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   ncyc, start_cyc, cfg_cyc, last_rsp;
    bit   got;

    vecs[0] = '{0, 26'd10000,    13'd13};
    vecs[1] = '{1, 26'd11075584, 13'd1};
    vecs[2] = '{0, 26'd3328,     13'd3328};
    vecs[3] = '{1, 26'd0,        13'd0};
    vecs[4] = '{0, 26'd6658,     13'd0};
    vecs[5] = '{1, 26'd3330,     13'd1};

    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    cfg_valid = 1'b0;
    cfg_n     = '0;
    cfg_mu    = '0;
    cur_n     = 13'd3329;
    #2;
    chk_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;

    // Requests before any configuration are never granted.
    req_valid = 2'b11;
    req_x[0]  = 26'd1234;
    req_x[1]  = 26'd5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("uncfg_ready", 64'(req_ready), 64'd0);
      tick();
    end
    req_valid = '0;

    do_cfg(3329, ncyc);
    chk("cfg_latency_uncfg", 64'(ncyc), 64'd1);

    for (int v = 0; v < 6; v++) begin
      req_x[vecs[v].id]     = vecs[v].x;
      req_x[1 - vecs[v].id] = 26'($urandom_range(0, 1000000));
      req_valid             = (vecs[v].id == 0) ? 2'b01 : 2'b10;
      #1;
      chk("vec_ready", 64'(req_ready), 64'(req_valid));
      push_exp(vecs[v].id, vecs[v].r);
      tick();
      req_valid = '0;
      chk("vec_busy", 64'(busy), 64'd1);
      repeat (8) tick();
      chk("vec_idle", 64'(busy), 64'd0);
    end
    chk("vec_all_rsp", 64'(exp_q.size()), 64'd0);

    // Both requesters continuously valid: grants alternate starting at req0.
    for (int i = 0; i < 8; i++) begin
      req_valid = 2'b11;
      req_x[0]  = 26'(10000 + i * 1000);
      req_x[1]  = 26'(i * 3330);
      #1;
      chk("fair_grant", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      push_exp(i % 2, mod_of(req_x[i % 2]));
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    chk("fair_all_rsp", 64'(exp_q.size()), 64'd0);

    // Stream from req0, then request a new modulus mid-stream.
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b01;
      req_x[0]  = 26'(20000 + i * 777);
      #1;
      chk("stream_ready", 64'(req_ready), 64'd1);
      push_exp(0, mod_of(req_x[0]));
      tick();
    end
    last_rsp  = exp_q[exp_q.size() - 1].cyc;
    cfg_n     = 13'd7681;
    cfg_mu    = mu_of(7681);
    cfg_valid = 1'b1;
    req_x[0]  = 26'd10000;
    start_cyc = cyc;
    cfg_cyc   = 0;
    #1;
    chk("cfg_blocks_ready", 64'(req_ready), 64'd0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (cfg_ready) begin
        got     = 1'b1;
        cfg_cyc = cyc;
      end else begin
        chk("drain_ready", 64'(req_ready), 64'd0);
      end
    end
    chk("mid_cfg_ready_seen", 64'(got), 64'd1);
    chk("old_results_done", 64'(exp_q.size()), 64'd0);
    chk("cfg_after_last_rsp", 64'(cfg_cyc > last_rsp), 64'd1);
    chk("cfg_cost", 64'((cfg_cyc - start_cyc) <= LAT + 3), 64'd1);
    tick();
    cfg_valid = 1'b0;
    cur_n     = 13'd7681;
    #1;
    chk("new_mod_ready", 64'(req_ready), 64'd1);
    push_exp(0, 13'd2319);
    tick();
    req_valid = '0;
    repeat (8) tick();
    chk("new_mod_rsp", 64'(exp_q.size()), 64'd0);

    // Reset with four ops in flight: none of them may come back.
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b10;
      req_x[1]  = 26'(1000 + i);
      #1;
      chk("pre_rst_ready", 64'(req_ready), 64'd2);
      tick();
    end
    chk("busy_inflight", 64'(busy), 64'd1);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_outputs("async_rst");
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("post_rst_ready", 64'(req_ready), 64'd0);
    chk("post_rst_cfgd", 64'(configured), 64'd0);
    req_valid = '0;

    // Lone requester req1 with req0 idle: granted every cycle.
    do_cfg(3329, ncyc);
    for (int i = 0; i < 6; i++) begin
      req_valid = 2'b10;
      req_x[0]  = 26'($urandom_range(0, 1000000));
      req_x[1]  = 26'(3329 * i + 50 * i + 7);
      #1;
      chk("lone_ready", 64'(req_ready), 64'd2);
      push_exp(1, mod_of(req_x[1]));
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    chk("lone_all_rsp", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
